// File: rtl/register_pipeline_pkg.sv
// Shared constants and helpers for the register-pipeline handshake blocks.
// Parameter limits and occupancy counter sizing live here.
package register_pipeline_pkg;

    localparam int MIN_WORD_WIDTH = 1;
    localparam int MIN_DEPTH      = 1;

    // Width able to hold every count from 0 to depth inclusive.
    function automatic int clog2_plus1(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic bit params_ok(input int word_width, input int depth);
        return (word_width >= MIN_WORD_WIDTH) && (depth >= MIN_DEPTH);
    endfunction

endpackage

// File: rtl/register_pipeline_stage.sv
// One elastic stage: valid flag plus data word, async reset, sync clear.
// Data only moves when a real word is loaded, so bubbles never toggle it.
module register_pipeline_stage
    import register_pipeline_pkg::*;
#(
    parameter int                    WORD_WIDTH  = 8,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  areset_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  up_valid,
    input  logic [WORD_WIDTH-1:0] up_data,
    output logic                  valid,
    output logic [WORD_WIDTH-1:0] data
);

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= up_valid;
        end
    end

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            data <= RESET_VALUE;
        end else if (clear) begin
            data <= RESET_VALUE;
        end else if (load && up_valid) begin
            data <= up_data;
        end
    end

endmodule

// File: rtl/register_pipeline_elastic.sv
// DEPTH-stage elastic register chain with valid/ready handshake.
// Define REGISTER_PIPELINE_OCCUPANCY_EN to add the occupancy output.
module register_pipeline_elastic
    import register_pipeline_pkg::*;
#(
    parameter int                    WORD_WIDTH  = 0,
    parameter int                    DEPTH       = 2,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  areset_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
    output logic [WORD_WIDTH-1:0] out_data,
    output logic [clog2_plus1(DEPTH)-1:0] occupancy
`else
    output logic [WORD_WIDTH-1:0] out_data
`endif
);

    if (!params_ok(WORD_WIDTH, DEPTH)) begin : g_bad_params
        $error("register_pipeline_elastic: WORD_WIDTH and DEPTH must be >= 1");
    end

    logic [DEPTH-1:0]      stage_valid;
    logic [DEPTH-1:0]      stage_ready;
    logic [WORD_WIDTH-1:0] stage_data [DEPTH];

    // Ready ripples back from the output so a full chain still streams.
    always_comb begin
        stage_ready = '0;
        stage_ready[DEPTH-1] = !stage_valid[DEPTH-1] || out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            stage_ready[k] = !stage_valid[k] || stage_ready[k+1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic                  up_valid;
        logic [WORD_WIDTH-1:0] up_data;

        if (k == 0) begin : g_first
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_chain
            assign up_valid = stage_valid[k-1];
            assign up_data  = stage_data[k-1];
        end

        register_pipeline_stage #(
            .WORD_WIDTH  (WORD_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clock    (clock),
            .areset_n (areset_n),
            .clear    (clear),
            .load     (stage_ready[k]),
            .up_valid (up_valid),
            .up_data  (up_data),
            .valid    (stage_valid[k]),
            .data     (stage_data[k])
        );
    end

    assign in_ready  = stage_ready[0] && !clear;
    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
    localparam int OCC_W = clog2_plus1(DEPTH);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            occupancy <= '0;
        end else if (clear) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_register_pipeline_elastic.sv
// Bench for register_pipeline_elastic: DEPTH=3 directed table plus a
// DEPTH=1 twin, both tracked by scoreboard queues under random traffic.
module tb_register_pipeline_elastic;

    localparam logic [7:0] RV_A = 8'h5A;
    localparam logic [7:0] RV_B = 8'hC3;

    logic       clock;
    logic       areset_n;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       a_in_ready, a_out_valid;
    logic [7:0] a_out_data;
    logic       b_in_ready, b_out_valid;
    logic [7:0] b_out_data;
`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
    logic [1:0] a_occ;
    logic [0:0] b_occ;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] q_a [$];
    logic [7:0] q_b [$];

    register_pipeline_elastic #(
        .WORD_WIDTH  (8),
        .DEPTH       (3),
        .RESET_VALUE (RV_A)
    ) u_dut_a (
        .clock     (clock),
        .areset_n  (areset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
        .out_data  (a_out_data),
        .occupancy (a_occ)
`else
        .out_data  (a_out_data)
`endif
    );

    register_pipeline_elastic #(
        .WORD_WIDTH  (8),
        .DEPTH       (1),
        .RESET_VALUE (RV_B)
    ) u_dut_b (
        .clock     (clock),
        .areset_n  (areset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
        .out_data  (b_out_data),
        .occupancy (b_occ)
`else
        .out_data  (b_out_data)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       clr;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        string      nm;
    } vec_t;

    vec_t vt [$];

    function automatic vec_t mk(input logic iv, input logic [7:0] id,
                                input logic ordy, input logic clr,
                                input logic e_ir, input logic e_ov,
                                input logic [7:0] e_od, input string nm);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.clr = clr;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.nm = nm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_out(input string nm, inout logic [7:0] q [$],
                          input logic [7:0] act);
        logic [7:0] exp;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s: got word %h expected no word", nm, act);
        end else begin
            exp = q.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, act, exp);
            end
        end
    endtask

    // Drive one cycle, check pre-edge outputs, update scoreboards, clock it.
    task automatic step(input logic iv, input logic [7:0] id,
                        input logic ordy, input logic clr, input bit dchk,
                        input logic e_ir, input logic e_ov,
                        input logic [7:0] e_od, input string nm);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        clear     = clr;
        #1;
        if (dchk) begin
            chk({nm, ".in_ready"}, {7'd0, a_in_ready}, {7'd0, e_ir});
            chk({nm, ".out_valid"}, {7'd0, a_out_valid}, {7'd0, e_ov});
            chk({nm, ".out_data"}, a_out_data, e_od);
        end
`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
        chk({nm, ".occ_a"}, {6'd0, a_occ}, 8'(q_a.size()));
        chk({nm, ".occ_b"}, {7'd0, b_occ}, 8'(q_b.size()));
`endif
        if (a_out_valid && out_ready) sb_out({nm, ".sb_a"}, q_a, a_out_data);
        if (b_out_valid && out_ready) sb_out({nm, ".sb_b"}, q_b, b_out_data);
        if (clr) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (in_valid && a_in_ready) q_a.push_back(in_data);
            if (in_valid && b_in_ready) q_b.push_back(in_data);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        areset_n  = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset.out_valid_a", {7'd0, a_out_valid}, 8'd0);
        chk("reset.out_data_a", a_out_data, RV_A);
        chk("reset.in_ready_a", {7'd0, a_in_ready}, 8'd1);
        chk("reset.out_data_b", b_out_data, RV_B);
        areset_n = 1'b1;

        // Streaming: word i+1 accepted at step i emerges at step i+3.
        for (int i = 0; i < 13; i++) begin
            vt.push_back(mk(i < 10, (i < 10) ? 8'(i + 1) : 8'h00, 1'b1, 1'b0,
                            1'b1, i >= 3, (i >= 3) ? 8'(i - 2) : RV_A,
                            $sformatf("stream%0d", i)));
        end
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h0A, "stream_hold"));
        // Fill with downstream stalled, then release.
        vt.push_back(mk(1, 8'hA1, 0, 0, 1, 0, 8'h0A, "fill0"));
        vt.push_back(mk(1, 8'hA2, 0, 0, 1, 0, 8'h0A, "fill1"));
        vt.push_back(mk(1, 8'hA3, 0, 0, 1, 0, 8'h0A, "fill2"));
        vt.push_back(mk(1, 8'hA4, 0, 0, 0, 1, 8'hA1, "full0"));
        vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8'hA1, "full1"));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA1, "drain0"));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA2, "drain1"));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA3, "drain2"));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'hA3, "drain3"));
        // Full chain passing one word in and one out per cycle.
        vt.push_back(mk(1, 8'hB1, 0, 0, 1, 0, 8'hA3, "thru0"));
        vt.push_back(mk(1, 8'hB2, 0, 0, 1, 0, 8'hA3, "thru1"));
        vt.push_back(mk(1, 8'hB3, 0, 0, 1, 0, 8'hA3, "thru2"));
        vt.push_back(mk(1, 8'hB4, 1, 0, 1, 1, 8'hB1, "thru3"));
        vt.push_back(mk(1, 8'hB5, 1, 0, 1, 1, 8'hB2, "thru4"));
        vt.push_back(mk(1, 8'hB6, 1, 0, 1, 1, 8'hB3, "thru5"));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hB4, "thru6"));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hB5, "thru7"));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hB6, "thru8"));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'hB6, "thru9"));
        // Clear with two words in flight.
        vt.push_back(mk(1, 8'hC1, 0, 0, 1, 0, 8'hB6, "clr0"));
        vt.push_back(mk(1, 8'hC2, 0, 0, 1, 0, 8'hB6, "clr1"));
        vt.push_back(mk(1, 8'hC3, 0, 1, 0, 0, 8'hB6, "clr2"));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, RV_A, "clr3"));
        vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, RV_A, "clr4"));

        foreach (vt[i]) begin
            step(vt[i].iv, vt[i].id, vt[i].ordy, vt[i].clr, 1'b1,
                 vt[i].e_ir, vt[i].e_ov, vt[i].e_od, vt[i].nm);
        end

        // Async reset pulse between edges with two words held.
        step(1, 8'hD1, 0, 0, 1, 1, 0, RV_A, "rst0");
        step(1, 8'hD2, 0, 0, 1, 1, 0, RV_A, "rst1");
        in_valid = 1'b0;
        #2;
        areset_n = 1'b0;
        #1;
        chk("rst.async.out_valid_a", {7'd0, a_out_valid}, 8'd0);
        chk("rst.async.out_data_a", a_out_data, RV_A);
        chk("rst.async.out_valid_b", {7'd0, b_out_valid}, 8'd0);
        chk("rst.async.out_data_b", b_out_data, RV_B);
        #1;
        areset_n = 1'b1;
        q_a.delete();
        q_b.delete();
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, 1, 0, 1, 1, 0, RV_A, $sformatf("rst_after%0d", i));
        end

        // Random traffic against both scoreboards.
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0,
                 1'b0, 1'b0, 1'b0, 8'h00, "rand");
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, "drain");
        end
        chk("final.q_a_empty", 8'(q_a.size()), 8'd0);
        chk("final.q_b_empty", 8'(q_b.size()), 8'd0);
        chk("final.out_valid_a", {7'd0, a_out_valid}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
